// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first bit-serial subtractor, one full-subtractor cell plus borrow FF
module bit_serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   // Result bits collected so far; the newest bit sits at the MSB end.
   logic [WIDTH-2:0] sr;
   logic             br;
   logic [CW-1:0]    count;

   logic             ai;
   logic             bi;
   logic             d;
   logic             br_nxt;
   logic             last;
   logic [WIDTH-1:0] shifted;

   // Full-subtractor cell on the current LSBs and the stored borrow.
   assign ai      = sa[0];
   assign bi      = sb[0];
   assign d       = ai ^ bi ^ br;
   assign br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
   assign last    = (count == CW'(WIDTH - 1));
   assign shifted = {d, sr};

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; unused encodings fall back to IDLE.
   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:  state_nxt = start ? S_SHIFT : S_IDLE;
         S_SHIFT: state_nxt = last ? S_DONE : S_SHIFT;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status decode from the next state so busy/done can be registered.
   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      case (state_nxt)
         S_SHIFT: busy_nxt = 1'b1;
         S_DONE: begin
            busy_nxt = 1'b1;
            done_nxt = 1'b1;
         end
         default: begin
            busy_nxt = 1'b0;
            done_nxt = 1'b0;
         end
      endcase
   end

   // Registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
      end
   end

   // Operand capture, serial datapath and result publication on the last bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa         <= '0;
         sb         <= '0;
         sr         <= '0;
         br         <= 1'b0;
         count      <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  sr    <= '0;
                  br    <= 1'b0;
                  count <= '0;
               end
            end
            S_SHIFT: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               sr    <= shifted[WIDTH-1:1];
               br    <= br_nxt;
               count <= count + 1'b1;
               if (last) begin
                  diff       <= shifted;
                  borrow_out <= br_nxt;
               end
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

endmodule
